// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, RV32I opcodes,
// instruction classes and the encodings of the datapath select fields.
package ctrl_pkg;

  typedef enum logic [2:0] {
    RST_S,
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_LUI,
    CL_AUIPC,
    CL_JAL,
    CL_JALR,
    CL_BRANCH,
    CL_LOAD,
    CL_STORE,
    CL_OPIMM,
    CL_OP,
    CL_ILLEGAL
  } op_class_t;

  // RV32I base opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Immediate generator format select
  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;
  localparam logic [1:0] IMM_U    = 2'b10;
  localparam logic [1:0] IMM_NONE = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_JAL   = 2'b01;
  localparam logic [1:0] PC_BR    = 2'b10;
  localparam logic [1:0] PC_ALU   = 2'b11;

  // Register writeback source select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // Width of the memory wait counter; covers timeouts up to 255 cycles
  localparam int WAIT_W = 8;

endpackage

// File: rtl/ctrl_decoder.sv
// Opcode classifier: maps inst[6:0] to an instruction class, a legality flag
// and the immediate format the datapath should build for it.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       legal,
  output logic [1:0] immsel
);

  // Classify the opcode; anything outside the RV32I base set is illegal
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    op_class = CL_ILLEGAL;
    immsel   = IMM_NONE;
    case (opcode)
      OPC_LUI:    begin op_class = CL_LUI;    immsel = IMM_U;    end
      OPC_AUIPC:  begin op_class = CL_AUIPC;  immsel = IMM_U;    end
      OPC_JAL:    begin op_class = CL_JAL;    immsel = IMM_NONE; end
      OPC_JALR:   begin op_class = CL_JALR;   immsel = IMM_I;    end
      OPC_BRANCH: begin op_class = CL_BRANCH; immsel = IMM_NONE; end
      OPC_LOAD:   begin op_class = CL_LOAD;   immsel = IMM_I;    end
      OPC_STORE:  begin op_class = CL_STORE;  immsel = IMM_S;    end
      OPC_OPIMM:  begin op_class = CL_OPIMM;  immsel = IMM_I;    end
      OPC_OP:     begin op_class = CL_OP;     immsel = IMM_NONE; end
      default:    begin op_class = CL_ILLEGAL; immsel = IMM_NONE; end
    endcase
    legal = (op_class != CL_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM. Sequences fetch, decode, execute, memory and
// writeback, drives the datapath enables, and traps on illegal opcodes or on
// a memory handshake that never completes.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic [1:0]  immsel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  op_class_t         cls_q;
  logic [1:0]        imm_q;
  logic [WAIT_W-1:0] wait_cnt;

  op_class_t         dec_cls;
  logic              dec_legal;
  logic [1:0]        dec_imm;

  // Operand fields of the instruction belong to the datapath, not this FSM
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst[31:7];

  ctrl_decoder u_decoder (
    .opcode   (inst[6:0]),
    .op_class (dec_cls),
    .legal    (dec_legal),
    .immsel   (dec_imm)
  );

  // State sequencing, decoded-class capture and memory wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RST_S;
      cls_q    <= CL_OP;
      imm_q    <= IMM_I;
      wait_cnt <= '0;
    end else begin
      // NOTE: state elements use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      case (state)
        RST_S: state <= FETCH;

        FETCH: begin
          if (mem_ready) begin
            state    <= DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state    <= TRAP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DECODE: begin
          cls_q <= dec_cls;
          imm_q <= dec_imm;
          state <= dec_legal ? EXECUTE : TRAP;
        end

        EXECUTE: begin
          case (cls_q)
            CL_JAL, CL_JALR, CL_BRANCH: state <= FETCH;
            CL_LOAD, CL_STORE:          state <= MEM;
            default:                    state <= WB;
          endcase
        end

        MEM: begin
          if (mem_ready) begin
            state    <= (cls_q == CL_LOAD) ? WB : FETCH;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state    <= TRAP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

  // Datapath controls; decoded each cycle because ir_we, pc_we and pc_sel
  // must react to mem_ready and br_taken in the same cycle they are sampled
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    immsel   = IMM_I;
    pc_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    reg_we   = 1'b0;
    wb_sel   = WB_ALU;
    trap     = 1'b0;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
      end

      DECODE: immsel = dec_imm;

      EXECUTE: begin
        immsel = imm_q;
        case (cls_q)
          CL_JAL: begin
            pc_we  = 1'b1;
            pc_sel = PC_JAL;
            reg_we = 1'b1;
            wb_sel = WB_PC4;
          end
          CL_JALR: begin
            pc_we  = 1'b1;
            pc_sel = PC_ALU;
            reg_we = 1'b1;
            wb_sel = WB_PC4;
          end
          CL_BRANCH: begin
            pc_we  = 1'b1;
            pc_sel = br_taken ? PC_BR : PC_PLUS4;
          end
          default: ;
        endcase
      end

      MEM: begin
        immsel   = imm_q;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls_q == CL_STORE);
        pc_we    = (cls_q == CL_STORE) && mem_ready;
      end

      WB: begin
        immsel = imm_q;
        reg_we = 1'b1;
        wb_sel = (cls_q == CL_LOAD) ? WB_MEM : WB_ALU;
        pc_we  = 1'b1;
      end

      TRAP: trap = 1'b1;

      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each scenario queues the expected
// output vector as it drives a cycle and compares it at the falling edge.
module tb_multicycle_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_BEQ  = 32'h00000063;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_JALR = 32'h00000067;
  localparam logic [31:0] I_LUI  = 32'h000000B7;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic [1:0] immsel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       trap;
  } out_t;

  typedef struct {
    logic [31:0] inst;
    logic        rdy;
    logic        bt;
    out_t        exp;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, trap;
  logic [1:0]  immsel, pc_sel, wb_sel;

  out_t act;
  out_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  assign act = {mem_req, mem_we, addr_sel, ir_we, immsel, pc_we, pc_sel,
                reg_we, wb_sel, trap};

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst      (inst),
    .br_taken  (br_taken),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .immsel    (immsel),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .trap      (trap)
  );

  function automatic out_t mk(input logic mreq, input logic mwe, input logic asel,
                              input logic irwe, input logic [1:0] imm,
                              input logic pcwe, input logic [1:0] psel,
                              input logic rwe, input logic [1:0] wsel,
                              input logic trp);
    out_t r;
    r = '{mreq, mwe, asel, irwe, imm, pcwe, psel, rwe, wsel, trp};
    return r;
  endfunction

  function automatic out_t v_fetch(input logic rdy);
    return mk(H, L, L, rdy, 2'b00, L, 2'b00, L, 2'b00, L);
  endfunction

  function automatic out_t v_imm(input logic [1:0] imm);
    return mk(L, L, L, L, imm, L, 2'b00, L, 2'b00, L);
  endfunction

  function automatic out_t v_trap();
    return mk(L, L, L, L, 2'b00, L, 2'b00, L, 2'b00, H);
  endfunction

  // One clock of stimulus: inputs change just after the rising edge, the
  // expected vector is queued, and the call returns at the falling edge.
  task automatic drive(input logic [31:0] i, input logic rdy, input logic bt,
                       input out_t exp);
    @(posedge clk);
    #1;
    inst      = i;
    mem_ready = rdy;
    br_taken  = bt;
    sb_q.push_back(exp);
    @(negedge clk);
  endtask

  // Pulse reset for one cycle; the next drive() call lands in FETCH.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    br_taken  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    out_t want;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sb_q.push_back('0);
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %b want %b", k, act, want);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.push_back('0);
    @(negedge clk);
    want = sb_q.pop_front();
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL reset_rst_s: got %b want %b", act, want);
    end
    drive(I_ADDI, L, L, v_fetch(L));
    want = sb_q.pop_front();
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL reset_first_fetch: got %b want %b", act, want);
    end
  endtask

  task automatic test_addi();
    stim_t rows[$];
    out_t  want;
    do_reset();
    rows.push_back(stim_t'{I_ADDI, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_ADDI, L, L, v_imm(2'b00)});
    rows.push_back(stim_t'{I_ADDI, L, L, v_imm(2'b00)});
    rows.push_back(stim_t'{I_ADDI, L, L, mk(L, L, L, L, 2'b00, H, 2'b00, H, 2'b00, L)});
    rows.push_back(stim_t'{I_ADDI, L, L, v_fetch(L)});
    foreach (rows[k]) begin
      drive(rows[k].inst, rows[k].rdy, rows[k].bt, rows[k].exp);
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL addi[%0d]: got %b want %b", k, act, want);
      end
    end
  endtask

  task automatic test_branch();
    stim_t rows[$];
    out_t  want;
    do_reset();
    rows.push_back(stim_t'{I_BEQ, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_BEQ, L, L, v_imm(2'b11)});
    rows.push_back(stim_t'{I_BEQ, L, H, mk(L, L, L, L, 2'b11, H, 2'b10, L, 2'b00, L)});
    rows.push_back(stim_t'{I_BEQ, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_BEQ, L, L, v_imm(2'b11)});
    rows.push_back(stim_t'{I_BEQ, L, L, mk(L, L, L, L, 2'b11, H, 2'b00, L, 2'b00, L)});
    rows.push_back(stim_t'{I_BEQ, L, L, v_fetch(L)});
    foreach (rows[k]) begin
      drive(rows[k].inst, rows[k].rdy, rows[k].bt, rows[k].exp);
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL branch[%0d]: got %b want %b", k, act, want);
      end
    end
  endtask

  task automatic test_store_wait();
    stim_t rows[$];
    out_t  want;
    do_reset();
    rows.push_back(stim_t'{I_SW, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_SW, L, L, v_imm(2'b01)});
    rows.push_back(stim_t'{I_SW, L, L, v_imm(2'b01)});
    for (int w = 0; w < 3; w++)
      rows.push_back(stim_t'{I_SW, L, L, mk(H, H, H, L, 2'b01, L, 2'b00, L, 2'b00, L)});
    rows.push_back(stim_t'{I_SW, H, L, mk(H, H, H, L, 2'b01, H, 2'b00, L, 2'b00, L)});
    rows.push_back(stim_t'{I_SW, L, L, v_fetch(L)});
    foreach (rows[k]) begin
      drive(rows[k].inst, rows[k].rdy, rows[k].bt, rows[k].exp);
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL store_wait[%0d]: got %b want %b", k, act, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t rows[$];
    out_t  want;
    do_reset();
    rows.push_back(stim_t'{I_JAL, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_JAL, L, L, v_imm(2'b11)});
    rows.push_back(stim_t'{I_JAL, L, L, mk(L, L, L, L, 2'b11, H, 2'b01, H, 2'b10, L)});
    rows.push_back(stim_t'{I_JALR, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_JALR, L, L, v_imm(2'b00)});
    rows.push_back(stim_t'{I_JALR, L, L, mk(L, L, L, L, 2'b00, H, 2'b11, H, 2'b10, L)});
    rows.push_back(stim_t'{I_LUI, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_LUI, L, L, v_imm(2'b10)});
    rows.push_back(stim_t'{I_LUI, L, L, v_imm(2'b10)});
    rows.push_back(stim_t'{I_LUI, L, L, mk(L, L, L, L, 2'b10, H, 2'b00, H, 2'b00, L)});
    rows.push_back(stim_t'{I_ADD, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_ADD, L, L, v_imm(2'b11)});
    rows.push_back(stim_t'{I_ADD, L, L, v_imm(2'b11)});
    rows.push_back(stim_t'{I_ADD, L, L, mk(L, L, L, L, 2'b11, H, 2'b00, H, 2'b00, L)});
    rows.push_back(stim_t'{I_LW, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_LW, L, L, v_imm(2'b00)});
    rows.push_back(stim_t'{I_LW, L, L, v_imm(2'b00)});
    rows.push_back(stim_t'{I_LW, H, L, mk(H, L, H, L, 2'b00, L, 2'b00, L, 2'b00, L)});
    rows.push_back(stim_t'{I_LW, L, L, mk(L, L, L, L, 2'b00, H, 2'b00, H, 2'b01, L)});
    rows.push_back(stim_t'{I_LW, L, L, v_fetch(L)});
    foreach (rows[k]) begin
      drive(rows[k].inst, rows[k].rdy, rows[k].bt, rows[k].exp);
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got %b want %b", k, act, want);
      end
    end
  endtask

  task automatic test_timeout();
    out_t want;
    // Ready never arrives: 16 request cycles, then sticky trap
    do_reset();
    for (int k = 0; k < 19; k++) begin
      if (k < 16) drive(I_ADDI, L, L, v_fetch(L));
      else        drive(I_ADDI, H, L, v_trap());
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL timeout[%0d]: got %b want %b", k, act, want);
      end
    end
    // Reset clears the trap
    do_reset();
    drive(I_ADDI, L, L, v_fetch(L));
    want = sb_q.pop_front();
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL timeout_cleared: got %b want %b", act, want);
    end
    // Ready arriving on the last allowed cycle completes the fetch
    do_reset();
    for (int k = 0; k < 17; k++) begin
      if (k < 15)       drive(I_ADDI, L, L, v_fetch(L));
      else if (k == 15) drive(I_ADDI, H, L, v_fetch(H));
      else              drive(I_ADDI, L, L, v_imm(2'b00));
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL handshake_wins[%0d]: got %b want %b", k, act, want);
      end
    end
  endtask

  task automatic test_illegal();
    stim_t rows[$];
    out_t  want;
    do_reset();
    rows.push_back(stim_t'{I_BAD, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_BAD, L, L, v_imm(2'b11)});
    rows.push_back(stim_t'{I_BAD, H, L, v_trap()});
    rows.push_back(stim_t'{I_ADDI, H, H, v_trap()});
    foreach (rows[k]) begin
      drive(rows[k].inst, rows[k].rdy, rows[k].bt, rows[k].exp);
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL illegal[%0d]: got %b want %b", k, act, want);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    stim_t rows[$];
    out_t  want;
    do_reset();
    rows.push_back(stim_t'{I_LW, H, L, v_fetch(H)});
    rows.push_back(stim_t'{I_LW, L, L, v_imm(2'b00)});
    rows.push_back(stim_t'{I_LW, L, L, v_imm(2'b00)});
    rows.push_back(stim_t'{I_LW, L, L, mk(H, L, H, L, 2'b00, L, 2'b00, L, 2'b00, L)});
    foreach (rows[k]) begin
      drive(rows[k].inst, rows[k].rdy, rows[k].bt, rows[k].exp);
      want = sb_q.pop_front();
      n_cmp++;
      if (act !== want) begin
        n_err++;
        $display("FAIL mid_load[%0d]: got %b want %b", k, act, want);
      end
    end
    // Assert reset between clock edges while the load request is pending
    #1;
    rst_n = 1'b0;
    sb_q.push_back('0);
    #1;
    want = sb_q.pop_front();
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL mid_load_async_reset: got %b want %b", act, want);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.push_back('0);
    @(negedge clk);
    want = sb_q.pop_front();
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL mid_load_rst_s: got %b want %b", act, want);
    end
    drive(I_LW, L, L, v_fetch(L));
    want = sb_q.pop_front();
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL mid_load_refetch: got %b want %b", act, want);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_store_wait();
    test_back_to_back();
    test_timeout();
    test_illegal();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
